// File: rtl/conv_pe_kxk_mc.sv
// Multi-channel KxK convolution PE: a multiply stage, an adder tree, per-channel accumulation,
// then ReLU, round-half-up requantisation and saturation. Every stage advances only while the output can move.
module conv_pe_mul #(
  parameter int PW = 9,
  parameter int WW = 8
) (
  input  logic signed [PW-1:0]    pix_i,
  input  logic signed [WW-1:0]    wgt_i,
  output logic signed [PW+WW-1:0] prod_o
);
  assign prod_o = pix_i * wgt_i;
endmodule

module conv_pe_kxk_mc #(
  parameter int K            = 5,
  parameter int C_IN         = 1,
  parameter int PIXEL_WIDTH  = 9,
  parameter int WEIGHT_WIDTH = 8,
  parameter int BIAS_WIDTH   = 32,
  parameter int ACC_WIDTH    = 32,
  parameter int OUT_WIDTH    = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clear,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [K*K*PIXEL_WIDTH-1:0]          in_pix,
  input  logic [K*K*WEIGHT_WIDTH-1:0]         in_wgt,
  input  logic [BIAS_WIDTH-1:0]               in_bias,
  input  logic                                relu_en,
  input  logic [4:0]                          shift,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUT_WIDTH-1:0]                out_data,
  output logic [ACC_WIDTH-1:0]                out_acc
);
  localparam int KK = K * K;
  localparam int PRW = PIXEL_WIDTH + WEIGHT_WIDTH;
  localparam int CW = (C_IN > 1) ? $clog2(C_IN) : 1;
  localparam logic signed [ACC_WIDTH:0] QMAX = (ACC_WIDTH+1)'(2**(OUT_WIDTH-1) - 1);
  localparam logic signed [ACC_WIDTH:0] QMIN = (ACC_WIDTH+1)'(-(2**(OUT_WIDTH-1)));

  logic                               adv;
  logic [KK-1:0][PIXEL_WIDTH-1:0]     pix_a;
  logic [KK-1:0][WEIGHT_WIDTH-1:0]    wgt_a;
  logic [KK-1:0][PRW-1:0]             prod_d, prod_q;
  logic [1:0]                         vld_pipe_q;
  logic [BIAS_WIDTH-1:0]              bias1_q, bias2_q;
  logic signed [ACC_WIDTH-1:0]        psum_d, psum_q, acc_d, acc_q, r_d;
  logic [CW-1:0]                      cnt_q;
  logic                               last, done_q, out_vld_q;
  logic signed [ACC_WIDTH:0]          rnd, sum_r, q_full;
  logic [OUT_WIDTH-1:0]               q_d, out_data_q;
  logic [ACC_WIDTH-1:0]               out_acc_q;

  assign adv       = !out_vld_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_vld_q;
  assign out_data  = out_data_q;
  assign out_acc   = out_acc_q;
  assign pix_a     = in_pix;
  assign wgt_a     = in_wgt;

  for (genvar g = 0; g < KK; g++) begin : g_lane
    conv_pe_mul #(.PW(PIXEL_WIDTH), .WW(WEIGHT_WIDTH)) u_mul (
      .pix_i (pix_a[g]),
      .wgt_i (wgt_a[g]),
      .prod_o(prod_d[g])
    );
  end

  always_comb begin
    psum_d = '0;
    for (int i = 0; i < KK; i++) psum_d = psum_d + ACC_WIDTH'($signed(prod_q[i]));
  end

  // Channel 0 starts a fresh sum from the bias carried alongside the beat.
  assign last  = (cnt_q == CW'(C_IN - 1));
  assign acc_d = ((cnt_q == '0) ? ACC_WIDTH'($signed(bias2_q)) : acc_q) + psum_q;

  // One guard bit so the rounding offset cannot overflow the accumulator range.
  always_comb begin
    r_d    = (relu_en && acc_q[ACC_WIDTH-1]) ? '0 : acc_q;
    rnd    = ((ACC_WIDTH+1)'(1) << shift) >>> 1;
    sum_r  = {r_d[ACC_WIDTH-1], r_d} + rnd;
    q_full = sum_r >>> shift;
    if (q_full > QMAX)      q_d = QMAX[OUT_WIDTH-1:0];
    else if (q_full < QMIN) q_d = QMIN[OUT_WIDTH-1:0];
    else                    q_d = q_full[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      prod_q     <= '0;
      bias1_q    <= '0;
      bias2_q    <= '0;
      psum_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_acc_q  <= '0;
    end else begin
      if (adv) begin
        vld_pipe_q <= {vld_pipe_q[0], in_valid};
        prod_q     <= prod_d;
        bias1_q    <= in_bias;
        bias2_q    <= bias1_q;
        psum_q     <= psum_d;
        done_q     <= vld_pipe_q[1] && last;
        if (vld_pipe_q[1]) begin
          acc_q <= acc_d;
          cnt_q <= last ? '0 : cnt_q + 1'b1;
        end
        out_vld_q <= done_q;
        if (done_q) begin
          out_acc_q  <= r_d;
          out_data_q <= q_d;
        end
      end
      // Flush wins over advance; a finished result already in S4 survives.
      if (clear) begin
        vld_pipe_q <= '0;
        done_q     <= 1'b0;
        cnt_q      <= '0;
      end
    end
  end
endmodule

// File: tb/tb_conv_pe_kxk_mc.sv
// Bench for conv_pe_kxk_mc: three instances (C_IN = 1, 3, 4) checked against an integer model of the PE.
module tb_conv_pe_kxk_mc;
  localparam int KK = 25, PW = 9, WW = 8, AW = 32, OW = 8;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, relu_en = 1'b0;
  logic [4:0] shift = '0;
  logic [KK*PW-1:0] in_pix = '0;
  logic [KK*WW-1:0] in_wgt = '0;
  logic [31:0] in_bias = '0;
  logic [2:0] in_valid, in_ready, out_valid, out_ready;
  logic [OW-1:0] out_data [3];
  logic [AW-1:0] out_acc [3];
  int total = 0, bad = 0;
  int cur_pix [KK];
  int cur_wgt [KK];
  int cur_bias;

  always #5 clk = ~clk;

  conv_pe_kxk_mc #(.K(5), .C_IN(1)) u_c1 (.clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_pix(in_pix), .in_wgt(in_wgt),
    .in_bias(in_bias), .relu_en(relu_en), .shift(shift), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .out_acc(out_acc[0]));
  conv_pe_kxk_mc #(.K(5), .C_IN(3)) u_c3 (.clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_pix(in_pix), .in_wgt(in_wgt),
    .in_bias(in_bias), .relu_en(relu_en), .shift(shift), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .out_acc(out_acc[1]));
  conv_pe_kxk_mc #(.K(5), .C_IN(4)) u_c4 (.clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_pix(in_pix), .in_wgt(in_wgt),
    .in_bias(in_bias), .relu_en(relu_en), .shift(shift), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .out_acc(out_acc[2]));

  function automatic longint dot_cur();
    longint s = 0;
    for (int i = 0; i < KK; i++) s += longint'(cur_pix[i]) * longint'(cur_wgt[i]);
    return s;
  endfunction

  // Reference: 32-bit wrap, ReLU, floor((r + d/2) / d), clamp to the 8-bit range.
  task automatic model(input longint acc, input bit relu, input int sh, output longint r, output longint q);
    longint num, d;
    r = longint'(int'(acc));
    if (relu && r < 0) r = 0;
    if (sh == 0) q = r;
    else begin
      d = longint'(1) << sh;
      num = r + d / 2;
      q = num / d;
      if (num % d != 0 && num < 0) q = q - 1;
    end
    if (q > 127) q = 127;
    if (q < -128) q = -128;
  endtask

  task automatic drive_beat();
    for (int i = 0; i < KK; i++) begin
      in_pix[i*PW +: PW] = PW'(cur_pix[i]);
      in_wgt[i*WW +: WW] = WW'(cur_wgt[i]);
    end
    in_bias = 32'(cur_bias);
  endtask

  task automatic fill(input int p, input int w, input int b);
    for (int i = 0; i < KK; i++) begin cur_pix[i] = p; cur_wgt[i] = w; end
    cur_bias = b;
    drive_beat();
  endtask

  task automatic fill_rand();
    for (int i = 0; i < KK; i++) begin
      cur_pix[i] = int'($urandom_range(0, 255));
      cur_wgt[i] = int'($urandom_range(0, 255)) - 128;
    end
    cur_bias = int'($urandom_range(0, 20000)) - 10000;
    drive_beat();
  endtask

  task automatic present(input int idx);
    in_valid[idx] = 1'b1;
    @(posedge clk); #1;
    in_valid[idx] = 1'b0;
  endtask

  task automatic wait_valid(input int idx, input int maxc, output int n);
    n = 0;
    while (out_valid[idx] !== 1'b1 && n < maxc) begin @(posedge clk); #1; n++; end
  endtask

  task automatic watch(input int idx, input int cycles, output int cnt,
                       output logic [OW-1:0] d, output logic [AW-1:0] a);
    cnt = 0; d = '0; a = '0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (out_valid[idx] === 1'b1) begin cnt++; d = out_data[idx]; a = out_acc[idx]; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = '0; out_ready = '0;
    #12;
    total++; if (out_valid !== 3'b000) begin bad++; $display("FAIL reset_out_valid: got %b want 000", out_valid); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_data[i] !== '0 || out_acc[i] !== '0) begin
        bad++; $display("FAIL reset_out_regs[%0d]: got data=%0d acc=%0d want 0/0", i, out_data[i], out_acc[i]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 3'b111) begin bad++; $display("FAIL reset_in_ready: got %b want 111", in_ready); end
    out_ready = 3'b111;
  endtask

  task automatic test_basic();
    int n;
    relu_en = 1'b1; shift = 5'd0;
    fill(1, 1, 3);
    present(0);
    wait_valid(0, 8, n);
    total++; if (n != 3) begin bad++; $display("FAIL basic_latency: got %0d edges after accept, want 3", n); end
    total++; if (out_data[0] !== 8'd28) begin bad++; $display("FAIL basic_data: got %0d want 28", $signed(out_data[0])); end
    total++; if (out_acc[0] !== 32'd28) begin bad++; $display("FAIL basic_acc: got %0d want 28", $signed(out_acc[0])); end
    @(posedge clk); #1;
    total++; if (out_valid[0] !== 1'b0) begin bad++; $display("FAIL basic_valid_drop: got %b want 0", out_valid[0]); end
  endtask

  task automatic test_multichan();
    int c; logic [OW-1:0] d; logic [AW-1:0] a;
    relu_en = 1'b1; shift = 5'd2;
    fill(2, 3, -10); present(1);
    watch(1, 5, c, d, a);
    total++; if (c != 0) begin bad++; $display("FAIL multi_early_1: got %0d results want 0", c); end
    fill(2, 3, 99); present(1);
    watch(1, 5, c, d, a);
    total++; if (c != 0) begin bad++; $display("FAIL multi_early_2: got %0d results want 0", c); end
    fill(2, 3, 99); present(1);
    watch(1, 10, c, d, a);
    total++; if (c != 1) begin bad++; $display("FAIL multi_count: got %0d results want 1", c); end
    total++; if (a !== 32'd440) begin bad++; $display("FAIL multi_acc: got %0d want 440", $signed(a)); end
    total++; if (d !== 8'd110) begin bad++; $display("FAIL multi_data: got %0d want 110", $signed(d)); end
  endtask

  task automatic test_relu_sat();
    int c; logic [OW-1:0] d; logic [AW-1:0] a;
    fill(255, -1, 0);
    relu_en = 1'b1; shift = 5'd0;
    present(0); watch(0, 6, c, d, a);
    total++; if (c != 1 || d !== 8'd0 || a !== 32'd0) begin
      bad++; $display("FAIL relu_clip: got n=%0d data=%0d acc=%0d want 1/0/0", c, $signed(d), $signed(a)); end
    relu_en = 1'b0; shift = 5'd4;
    present(0); watch(0, 6, c, d, a);
    total++; if (c != 1 || a !== 32'(-6375)) begin
      bad++; $display("FAIL neg_acc: got n=%0d acc=%0d want 1/-6375", c, $signed(a)); end
    total++; if (d !== 8'h80) begin bad++; $display("FAIL neg_sat: got %0d want -128", $signed(d)); end
  endtask

  task automatic test_rounding();
    int bias_t [4] = '{6, 5, -6, 200};
    int sh_t [4]   = '{2, 2, 2, 0};
    int exp_t [4]  = '{2, 1, -1, 127};
    int c; logic [OW-1:0] d; logic [AW-1:0] a;
    relu_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fill(0, 0, bias_t[i]); shift = 5'(sh_t[i]);
      present(0); watch(0, 6, c, d, a);
      total++; if (c != 1 || d !== OW'(exp_t[i]) || a !== AW'(bias_t[i])) begin
        bad++; $display("FAIL round[%0d]: got n=%0d data=%0d acc=%0d want 1/%0d/%0d", i, c, $signed(d), $signed(a), exp_t[i], bias_t[i]);
      end
    end
  endtask

  task automatic test_random();
    int c; logic [OW-1:0] d; logic [AW-1:0] a; longint acc, r, q;
    for (int t = 0; t < 10; t++) begin
      relu_en = 1'($urandom_range(0, 1)); shift = 5'($urandom_range(0, 16));
      fill_rand(); acc = cur_bias + dot_cur();
      model(acc, relu_en, int'(shift), r, q);
      present(0); watch(0, 6, c, d, a);
      total++; if (c != 1 || d !== OW'(q) || a !== AW'(r)) begin
        bad++; $display("FAIL rand_c1[%0d]: got n=%0d data=%0d acc=%0d want 1/%0d/%0d", t, c, $signed(d), $signed(a), q, r);
      end
    end
    for (int t = 0; t < 4; t++) begin
      relu_en = 1'($urandom_range(0, 1)); shift = 5'($urandom_range(0, 31));
      acc = 0;
      for (int b = 0; b < 3; b++) begin
        fill_rand();
        if (b == 0) acc = cur_bias;
        acc += dot_cur();
        present(1);
      end
      model(acc, relu_en, int'(shift), r, q);
      watch(1, 8, c, d, a);
      total++; if (c != 1 || d !== OW'(q) || a !== AW'(r)) begin
        bad++; $display("FAIL rand_c3[%0d]: got n=%0d data=%0d acc=%0d want 1/%0d/%0d", t, c, $signed(d), $signed(a), q, r);
      end
    end
  endtask

  task automatic test_backpressure();
    longint qa [$]; longint qd [$]; longint r, q, ea, ed;
    int sent = 0, got = 0, cyc = 0;
    bit acc_prev = 1'b0, stall_prev = 1'b0;
    logic [OW-1:0] held_d; logic [AW-1:0] held_a;
    relu_en = 1'($urandom_range(0, 1)); shift = 5'($urandom_range(0, 8));
    in_valid[0] = 1'b0;
    while (got < 30 && cyc < 300) begin
      @(posedge clk); #1;
      if (cyc == 0) begin fill_rand(); in_valid[0] = 1'b1; end
      else if (acc_prev) begin
        if (sent < 30) fill_rand(); else in_valid[0] = 1'b0;
      end
      out_ready[0] = !(cyc >= 5 && cyc < 15);
      #1;
      if (stall_prev) begin
        total++; if (out_valid[0] !== 1'b1 || out_data[0] !== held_d || out_acc[0] !== held_a) begin
          bad++; $display("FAIL bp_hold@%0d: got v=%b data=%0d acc=%0d want 1/%0d/%0d", cyc, out_valid[0],
                          $signed(out_data[0]), $signed(out_acc[0]), $signed(held_d), $signed(held_a));
        end
      end
      total++; if (in_ready[0] !== out_ready[0]) begin
        bad++; $display("FAIL bp_in_ready@%0d: got %b want %b", cyc, in_ready[0], out_ready[0]); end
      if (out_valid[0] === 1'b1 && out_ready[0]) begin
        total++;
        if (qa.size() == 0) begin bad++; $display("FAIL bp_extra: got unexpected result data=%0d want none", $signed(out_data[0])); end
        else begin
          ea = qa.pop_front(); ed = qd.pop_front();
          if (out_acc[0] !== AW'(ea) || out_data[0] !== OW'(ed)) begin
            bad++; $display("FAIL bp_result[%0d]: got data=%0d acc=%0d want %0d/%0d", got, $signed(out_data[0]), $signed(out_acc[0]), ed, ea);
          end
        end
        got++;
      end
      stall_prev = (out_valid[0] === 1'b1) && !out_ready[0];
      held_d = out_data[0]; held_a = out_acc[0];
      acc_prev = in_valid[0] && (in_ready[0] === 1'b1);
      if (acc_prev) begin
        model(cur_bias + dot_cur(), relu_en, int'(shift), r, q);
        qa.push_back(r); qd.push_back(q); sent++;
      end
      cyc++;
    end
    total++; if (got != 30 || qa.size() != 0) begin
      bad++; $display("FAIL bp_count: got %0d results (%0d left) want 30/0", got, qa.size()); end
    in_valid[0] = 1'b0; out_ready[0] = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_fresh4(output longint r, output longint q);
    longint acc = 0;
    for (int b = 0; b < 4; b++) begin
      fill_rand();
      if (b == 0) acc = cur_bias;
      acc += dot_cur();
      present(2);
    end
    model(acc, relu_en, int'(shift), r, q);
  endtask

  task automatic test_clear_reset();
    int c, n; logic [OW-1:0] d; logic [AW-1:0] a; longint r, q;
    relu_en = 1'b0; shift = 5'($urandom_range(0, 10));
    fill_rand(); present(2);
    fill_rand(); present(2);
    fill_rand(); in_valid[2] = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid[2] = 1'b0;
    send_fresh4(r, q);
    watch(2, 12, c, d, a);
    total++; if (c != 1 || d !== OW'(q) || a !== AW'(r)) begin
      bad++; $display("FAIL clear_result: got n=%0d data=%0d acc=%0d want 1/%0d/%0d", c, $signed(d), $signed(a), q, r); end

    out_ready[0] = 1'b0;
    fill_rand(); present(2);
    fill_rand(); present(2);
    fill(1, 1, 0); present(0);
    wait_valid(0, 8, n);
    total++; if (out_valid[0] !== 1'b1) begin bad++; $display("FAIL rst_pending: got %b want 1", out_valid[0]); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 3'b000 || out_acc[0] !== '0 || out_data[0] !== '0) begin
      bad++; $display("FAIL rst_async: got v=%b acc=%0d data=%0d want 000/0/0", out_valid, out_acc[0], out_data[0]); end
    @(negedge clk); rst_n = 1'b1; out_ready = 3'b111;
    @(posedge clk); #1;
    send_fresh4(r, q);
    watch(2, 12, c, d, a);
    total++; if (c != 1 || d !== OW'(q) || a !== AW'(r)) begin
      bad++; $display("FAIL rst_restart: got n=%0d data=%0d acc=%0d want 1/%0d/%0d", c, $signed(d), $signed(a), q, r); end
  endtask

  initial begin
    in_valid = '0; out_ready = '0;
    test_reset();
    test_basic();
    test_multichan();
    test_relu_sat();
    test_rounding();
    test_random();
    test_backpressure();
    test_clear_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
